half_precision_divide: RTL and testbench
========================================

Name: half_precision_divide

Overview:
Iterative IEEE 754-2008 binary16 divider, quotient = Ain / Bin. It is the inverse-operation companion to the half-precision multiplier in the FPU and uses the same start/ready handshake and the same n/v/u/z/nan flag set. It computes one quotient bit per cycle with restoring division and has a fixed latency. Subnormal inputs and outputs are flushed to zero.

Parameters:
NAN_PATTERN, 16'h7E00, canonical quiet NaN emitted for every invalid result

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
Ain  in  16  dividend, binary16
Bin  in  16  divisor, binary16
quotient  out  16  Ain / Bin, held until the next accepted start
n  out  1  result is negative and not NaN
v  out  1  overflow: result is inf from finite operands, including x/0
u  out  1  underflow: nonzero exact result flushed to zero
z  out  1  result is ±0
nan  out  1  invalid result (NaN input, 0/0, inf/inf)
busy  out  1  high in every state except IDLE
ready  out  1  one-cycle pulse; quotient and flags valid from this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. It forces IDLE and clears quotient, all flags, ready and busy to 0.
- Reset mid-operation: abort, no ready pulse, outputs return to 0. The first start after reset deasserts is accepted.
- States: IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE.
- Latency: start is sampled on edge E0; Ain and Bin are latched at E0. Transitions:
  - E0: IDLE->UNPACK.
  - E1: UNPACK->DIVIDE.
  - E2..E14: 13 DIVIDE iterations; DIVIDE->NORMALIZE at E14.
  - E15: NORMALIZE->ROUND.
  - E16: ROUND->DONE; quotient and flags registered.
  - ready=1 only in DONE, i.e. the cycle after E16. E17: DONE->IDLE.
- The same fixed 16-edge latency applies to all inputs, special cases included.
- start is ignored while busy. Changes to Ain/Bin after E0 have no effect. A start in the IDLE cycle right after DONE is accepted, giving back-to-back operation.
- Unpack and classify:
  - exponent 0 is zero (a nonzero mantissa is flushed);
  - exponent 31 with mantissa 0 is inf;
  - exponent 31 with nonzero mantissa is NaN;
  - otherwise normal, with significand {1, mant}.
- Sign: Ain[15] ^ Bin[15].
- Special results, evaluated in UNPACK, with the datapath result discarded:
  - any NaN, 0/0, or inf/inf -> NAN_PATTERN, nan=1, n=0;
  - finite nonzero / 0 -> ±inf (16'h7C00 | sign<<15), v=1;
  - inf / finite -> ±inf, v=0;
  - 0 / nonzero, or finite / inf -> ±0, z=1.
- Divide: 11-bit dividend D={1,mA} and divisor S={1,mB}, remainder R=D initially.
  - Each iteration: if R>=S then q_bit=1 and R=R-S, else q_bit=0; then R=R<<1.
  - This yields q[12:0], where q[12] has weight 2^0.
- Exponent: E = eA - eB + 15, held as a signed 7-bit value.
- Normalize:
  - if q[12]=1: significand q[12:2], guard q[1], sticky = q[0] | (R!=0);
  - else: significand q[11:1], guard q[0], sticky = (R!=0), and E=E-1.
- Round: round-to-nearest-even. Round up when guard & (sticky | lsb). A significand carry-out sets the significand to 1.0 and E=E+1.
- Pack:
  - E>=31 -> ±inf, v=1;
  - E<=0 -> ±0, u=1, z=1;
  - else {sign, E[4:0], significand[9:0]}.
- n = sign & ~nan, and holds for ±0 and ±inf as well.

Decomposition:
- Package fp16_pkg holds:
  - field ranges: sign 15, exponent 14:10, mantissa 9:0;
  - BIAS=15, POS_INF=16'h7C00, CANON_NAN=16'h7E00;
  - the class enum {ZERO, NORMAL, INF, NAN};
  - the divider state enum.
- Sub-module fp16_classify (combinational): 16-bit operand in, class and {1,mant} out. It is shared with the multiplier.

Test Plan:
- Basic, with timing check: 0x4200/0x3E00 (3.0/1.5) -> 0x4000, all flags 0. busy high from E0, ready pulses exactly one cycle, after edge E16.
- Rounding and negative result:
  - 0x3C00/0x4200 (1/3) -> 0x3555;
  - 0xC600/0x4000 (-6/2) -> 0xC200, n=1.
- Specials:
  - 0x3C00/0x0000 -> 0x7C00, v=1;
  - 0x0000/0x0000 -> 0x7E00, nan=1;
  - 0x7C00/0xFC00 -> 0x7E00, nan=1;
  - 0x4000/0x7C00 -> 0x0000, z=1;
  - 0x7E01/0x3C00 -> 0x7E00, nan=1;
  - each still takes the full 16-edge latency.
- Range limits:
  - 0x7BFF/0x3800 -> 0x7C00, v=1;
  - 0x0400/0x4000 -> 0x0000, u=1, z=1;
  - subnormal 0x0001/0x3C00 -> 0x0000, z=1, u=0.
- Handshake:
  - start held high across an entire operation -> exactly one operation, then a second accepted in the IDLE cycle after DONE;
  - Ain/Bin toggled after E0 -> result unchanged.
- Reset: assert reset at E5 during DIVIDE -> no ready pulse, all outputs 0 the next cycle, state IDLE. A following 0x4400/0x4000 (4/2) returns 0x4000.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, constants and type definitions for the FPU.
package fp16_pkg;

  localparam int unsigned SignBit = 15;
  localparam int unsigned ExpMsb  = 14;
  localparam int unsigned ExpLsb  = 10;
  localparam int unsigned ManMsb  = 9;

  localparam int          Bias     = 15;
  localparam logic [15:0] PosInf   = 16'h7C00;
  localparam logic [15:0] CanonNan = 16'h7E00;

  localparam int unsigned DivIters = 13;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNormal,
    ClsInf,
    ClsNan
  } fp_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNormalize,
    StRound,
    StDone
  } div_state_e;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 operand classifier; subnormals report as zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0] op_i,
  output logic        sign_o,
  output fp_class_e   cls_o,
  output logic [10:0] sig_o
);

  logic [4:0] exp;
  logic [9:0] man;

  always_comb begin
    sign_o = op_i[SignBit];
    exp    = op_i[ExpMsb:ExpLsb];
    man    = op_i[ManMsb:0];
    sig_o  = {1'b1, man};
    if (exp == 5'd0) begin
      cls_o = ClsZero;
    end else if (exp == 5'd31) begin
      cls_o = (man == 10'd0) ? ClsInf : ClsNan;
    end else begin
      cls_o = ClsNormal;
    end
  end

endmodule

// File: rtl/half_precision_divide.sv
// Iterative binary16 divider: restoring division, one quotient bit per cycle, fixed latency.
module half_precision_divide
  import fp16_pkg::*;
#(
  parameter logic [15:0] NAN_PATTERN = CanonNan
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] Ain,
  input  logic [15:0] Bin,
  output logic [15:0] quotient,
  output logic        n,
  output logic        v,
  output logic        u,
  output logic        z,
  output logic        nan,
  output logic        busy,
  output logic        ready
);

  div_state_e        state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic              special_q, special_d;
  logic [15:0]       spec_res_q, spec_res_d;
  logic              spec_v_q, spec_v_d, spec_z_q, spec_z_d, spec_nan_q, spec_nan_d;
  logic [11:0]       rem_q, rem_d;
  logic [10:0]       divisor_q, divisor_d;
  logic [12:0]       qbits_q, qbits_d;
  logic signed [6:0] exp_q, exp_d;
  logic [3:0]        iter_q, iter_d;
  logic [9:0]        mant_q, mant_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;
  logic [15:0]       quotient_q, quotient_d;
  logic              n_q, n_d, v_q, v_d, u_q, u_d, z_q, z_d, nan_q, nan_d;

  logic              a_sign, b_sign, sign_w, round_up;
  fp_class_e         a_cls, b_cls;
  logic [10:0]       a_sig, b_sig;
  logic [11:0]       rem_sub;
  logic [9:0]        mant_rnd;
  logic signed [6:0] exp_rnd;

  fp16_classify u_cls_a (.op_i(a_q), .sign_o(a_sign), .cls_o(a_cls), .sig_o(a_sig));
  fp16_classify u_cls_b (.op_i(b_q), .sign_o(b_sign), .cls_o(b_cls), .sig_o(b_sig));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_v_d   = spec_v_q;
    spec_z_d   = spec_z_q;
    spec_nan_d = spec_nan_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    qbits_d    = qbits_q;
    exp_d      = exp_q;
    iter_d     = iter_q;
    mant_d     = mant_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    quotient_d = quotient_q;
    n_d        = n_q;
    v_d        = v_q;
    u_d        = u_q;
    z_d        = z_q;
    nan_d      = nan_q;
    sign_w     = a_sign ^ b_sign;
    rem_sub    = rem_q;
    round_up   = 1'b0;
    mant_rnd   = mant_q;
    exp_rnd    = exp_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = Ain;
          b_d     = Bin;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        sign_d     = sign_w;
        rem_d      = {1'b0, a_sig};
        divisor_d  = b_sig;
        qbits_d    = '0;
        iter_d     = '0;
        exp_d      = {2'b00, a_q[ExpMsb:ExpLsb]} - {2'b00, b_q[ExpMsb:ExpLsb]} + 7'(Bias);
        special_d  = 1'b1;
        spec_v_d   = 1'b0;
        spec_z_d   = 1'b0;
        spec_nan_d = 1'b0;
        spec_res_d = '0;
        if (a_cls == ClsNan || b_cls == ClsNan || (a_cls == ClsZero && b_cls == ClsZero) ||
            (a_cls == ClsInf && b_cls == ClsInf)) begin
          spec_nan_d = 1'b1;
          spec_res_d = NAN_PATTERN;
        end else if (a_cls == ClsInf) begin
          spec_res_d = PosInf | {sign_w, 15'd0};
        end else if (b_cls == ClsZero) begin
          spec_res_d = PosInf | {sign_w, 15'd0};
          spec_v_d   = 1'b1;
        end else if (a_cls == ClsZero || b_cls == ClsInf) begin
          spec_res_d = {sign_w, 15'd0};
          spec_z_d   = 1'b1;
        end else begin
          special_d = 1'b0;
        end
        state_d = StDivide;
      end
      StDivide: begin
        // Remainder stays below twice the divisor, so 12 bits never overflow.
        if (rem_q >= {1'b0, divisor_q}) begin
          rem_sub = rem_q - {1'b0, divisor_q};
          qbits_d = {qbits_q[11:0], 1'b1};
        end else begin
          qbits_d = {qbits_q[11:0], 1'b0};
        end
        rem_d  = rem_sub << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(DivIters - 1)) begin
          state_d = StNormalize;
        end
      end
      StNormalize: begin
        if (qbits_q[12]) begin
          mant_d   = qbits_q[11:2];
          guard_d  = qbits_q[1];
          sticky_d = qbits_q[0] | (rem_q != '0);
        end else begin
          mant_d   = qbits_q[10:1];
          guard_d  = qbits_q[0];
          sticky_d = (rem_q != '0);
          exp_d    = exp_q - 7'sd1;
        end
        state_d = StRound;
      end
      StRound: begin
        round_up = guard_q & (sticky_q | mant_q[0]);
        mant_rnd = mant_q + 10'(round_up);
        if (round_up && (&mant_q)) begin
          exp_rnd = exp_q + 7'sd1;
        end
        u_d = 1'b0;
        if (special_q) begin
          quotient_d = spec_res_q;
          v_d        = spec_v_q;
          z_d        = spec_z_q;
          nan_d      = spec_nan_q;
          n_d        = sign_q & ~spec_nan_q;
        end else begin
          n_d   = sign_q;
          nan_d = 1'b0;
          if (exp_rnd >= 7'sd31) begin
            quotient_d = PosInf | {sign_q, 15'd0};
            v_d        = 1'b1;
            z_d        = 1'b0;
          end else if (exp_rnd <= 7'sd0) begin
            quotient_d = {sign_q, 15'd0};
            v_d        = 1'b0;
            u_d        = 1'b1;
            z_d        = 1'b1;
          end else begin
            quotient_d = {sign_q, exp_rnd[4:0], mant_rnd};
            v_d        = 1'b0;
            z_d        = 1'b0;
          end
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_v_q   <= 1'b0;
      spec_z_q   <= 1'b0;
      spec_nan_q <= 1'b0;
      rem_q      <= '0;
      divisor_q  <= '0;
      qbits_q    <= '0;
      exp_q      <= '0;
      iter_q     <= '0;
      mant_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      quotient_q <= '0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      u_q        <= 1'b0;
      z_q        <= 1'b0;
      nan_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_v_q   <= spec_v_d;
      spec_z_q   <= spec_z_d;
      spec_nan_q <= spec_nan_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      qbits_q    <= qbits_d;
      exp_q      <= exp_d;
      iter_q     <= iter_d;
      mant_q     <= mant_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      quotient_q <= quotient_d;
      n_q        <= n_d;
      v_q        <= v_d;
      u_q        <= u_d;
      z_q        <= z_d;
      nan_q      <= nan_d;
    end
  end

  assign quotient = quotient_q;
  assign n        = n_q;
  assign v        = v_q;
  assign u        = u_q;
  assign z        = z_q;
  assign nan      = nan_q;
  assign busy     = (state_q != StIdle);
  assign ready    = (state_q == StDone);

endmodule

// File: tb/tb_half_precision_divide.sv
// Self-checking bench for half_precision_divide: directed table, handshake/reset sequences, random.
module tb_half_precision_divide;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] Ain, Bin, quotient;
  logic        n, v, u, z, nan, busy, ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  half_precision_divide dut (
    .clk(clk), .reset(reset), .start(start), .Ain(Ain), .Bin(Bin), .quotient(quotient),
    .n(n), .v(v), .u(u), .z(z), .nan(nan), .busy(busy), .ready(ready)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [4:0]  f;  // {n, v, u, z, nan}
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] result();
    return {11'd0, quotient, n, v, u, z, nan};
  endfunction

  // Reference: exact rational quotient, rounded to nearest-even from the true remainder.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, na, nb, e, num, sig, rem;
    logic s;
    bit za, zb, ia, ib, xa, xb;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 31) && (a[9:0] == 0);
    ib = (eb == 31) && (b[9:0] == 0);
    xa = (ea == 31) && (a[9:0] != 0);
    xb = (eb == 31) && (b[9:0] != 0);
    s  = a[15] ^ b[15];
    if (xa || xb || (za && zb) || (ia && ib)) return {11'd0, 16'h7E00, 5'b00001};
    if (ia) return {11'd0, s, 15'h7C00, s, 4'b0000};
    if (zb) return {11'd0, s, 15'h7C00, s, 4'b1000};
    if (za || ib) return {11'd0, s, 15'h0000, s, 4'b0010};
    na = 1024 + int'(a[9:0]);
    nb = 1024 + int'(b[9:0]);
    e  = ea - eb + 15;
    if (na >= nb) begin
      num = na << 10;
    end else begin
      num = na << 11;
      e--;
    end
    sig = num / nb;
    rem = num % nb;
    if (2 * rem > nb || (2 * rem == nb && sig % 2 == 1)) sig++;
    if (sig == 2048) begin
      sig = 1024;
      e++;
    end
    if (e >= 31) return {11'd0, s, 15'h7C00, s, 4'b1000};
    if (e <= 0) return {11'd0, s, 15'h0000, s, 4'b0110};
    return {11'd0, s, e[4:0], sig[9:0], s, 4'b0000};
  endfunction

  // Leaves start high; returns #1 after the accepting edge E0.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    Ain   = a;
    Bin   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after E0 until ready is seen; returns at the negedge of the DONE cycle.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ready && lat < 40);
  endtask

  vec_t        vecs[14];
  int          lat, rdy_seen;
  logic [15:0] ra, rb;

  initial begin
    vecs[0]  = '{16'h4200, 16'h3E00, 16'h4000, 5'b00000, "basic_3_div_1p5"};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 5'b00000, "one_third"};
    vecs[2]  = '{16'hC600, 16'h4000, 16'hC200, 5'b10000, "neg6_div_2"};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 5'b01000, "one_div_zero"};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, 5'b00001, "zero_div_zero"};
    vecs[5]  = '{16'h7C00, 16'hFC00, 16'h7E00, 5'b00001, "inf_div_ninf"};
    vecs[6]  = '{16'h4000, 16'h7C00, 16'h0000, 5'b00010, "two_div_inf"};
    vecs[7]  = '{16'h7E01, 16'h3C00, 16'h7E00, 5'b00001, "nan_input"};
    vecs[8]  = '{16'h7BFF, 16'h3800, 16'h7C00, 5'b01000, "overflow"};
    vecs[9]  = '{16'h0400, 16'h4000, 16'h0000, 5'b00110, "underflow"};
    vecs[10] = '{16'h0001, 16'h3C00, 16'h0000, 5'b00010, "subnormal_flush"};
    vecs[11] = '{16'hFC00, 16'h4000, 16'hFC00, 5'b10000, "ninf_div_2"};
    vecs[12] = '{16'h8000, 16'h4000, 16'h8000, 5'b10010, "nzero_div_2"};
    vecs[13] = '{16'hBC00, 16'h0000, 16'hFC00, 5'b11000, "neg_div_zero"};

    reset = 1'b1;
    start = 1'b0;
    Ain   = '0;
    Bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {14'd0, quotient, n, v, u, z, nan, busy, ready}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy_e0"}, 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(lat);
      check({vecs[i].name, "_latency"}, lat, 16);
      check(vecs[i].name, result(), {11'd0, vecs[i].q, vecs[i].f});
      check({vecs[i].name, "_model"}, result(), model(vecs[i].a, vecs[i].b));
      @(negedge clk);
      check({vecs[i].name, "_ready_pulse"}, {30'd0, ready, busy}, 32'd0);
    end

    // start held high: one op, then a second accepted in the IDLE cycle after DONE
    launch(16'h4400, 16'h4000);
    wait_done(lat);
    check("hold_latency", lat, 16);
    check("hold_result1", result(), {11'd0, 16'h4000, 5'b00000});
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 32'd0);
    Ain = 16'hC600;
    Bin = 16'h4000;
    @(posedge clk);
    #1;
    check("hold_second_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat);
    check("hold_latency2", lat, 16);
    check("hold_result2", result(), {11'd0, 16'hC200, 5'b10000});

    // operands changing after E0 must not disturb the result
    launch(16'h3C00, 16'h4200);
    start = 1'b0;
    Ain   = 16'hFFFF;
    Bin   = 16'h0000;
    wait_done(lat);
    check("toggle_latency", lat, 16);
    check("toggle_result", result(), {11'd0, 16'h3555, 5'b00000});

    // reset asserted so that it is sampled at E5
    launch(16'h4200, 16'h3E00);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_outputs", {14'd0, quotient, n, v, u, z, nan, busy, ready}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready) rdy_seen++;
    end
    check("reset_no_ready", rdy_seen, 0);
    launch(16'h4400, 16'h4000);
    start = 1'b0;
    wait_done(lat);
    check("after_reset_latency", lat, 16);
    check("after_reset_result", result(), {11'd0, 16'h4000, 5'b00000});

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 != 0) begin
        ra[14:10] = 5'($urandom_range(8, 24));
        rb[14:10] = 5'($urandom_range(8, 24));
      end
      launch(ra, rb);
      start = 1'b0;
      wait_done(lat);
      check($sformatf("rand_latency %h/%h", ra, rb), lat, 16);
      check($sformatf("rand %h/%h", ra, rb), result(), model(ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
